// File: rtl/interleaver_sched.sv
// Junction sequencer for interleaver_set: loads the sweep-start pattern from a config stream
// and steps cycle_index through each pass. Optional sweep monitor: define INTLV_SWEEP_MON_EN.
module interleaver_sched #(
   parameter int p     = 32,
   parameter int fo    = 2,
   parameter int z     = 8,
   parameter int ec    = 2,
   parameter int CFG_W = 16,
   localparam int NW      = p * fo / z,
   localparam int CPC     = NW + ec,
   localparam int LPZ     = (p == z) ? 1 : $clog2(p / z),
   localparam int SS_BITS = LPZ * fo * z,
   localparam int NWORDS  = (SS_BITS + CFG_W - 1) / CFG_W,
   localparam int CIW     = (CPC > 1) ? $clog2(CPC) : 1,
   localparam int EIW     = (NW > 1) ? $clog2(NW) : 1,
   localparam int SNW     = (fo > 1) ? $clog2(fo) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CFG_W-1:0]   cfg_data,
   output logic               cfg_done,
   output logic [SS_BITS-1:0] sweepstart,
   input  logic               start,
   input  logic               continuous,
   input  logic               stall,
   input  logic               abort,
   output logic               busy,
   output logic [CIW-1:0]     cycle_index,
   output logic [EIW-1:0]     eff_cycle_index,
   output logic               idx_valid,
   output logic               junction_done,
   output logic [SNW-1:0]     sweep_num,
   output logic               sweep_first
);

   localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);
   localparam logic [CIW-1:0] CI_LAST   = CIW'(CPC - 1);
   // One extra bit so NW == 2**CIW (ec == 0) still compares correctly.
   localparam logic [CIW:0]   NW_X      = (CIW + 1)'(NW);

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      IDLE  = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t               state_r;
   logic                 cfg_ready_r;
   logic                 cfg_done_r;
   logic                 busy_r;
   logic                 jd_r;
   logic [CIW-1:0]       ci_r;
   logic [WCW-1:0]       word_cnt_r;
   logic [SS_BITS-1:0]   ss_r;
   logic                 acc_s;
   logic                 last_s;
   logic [WCW-1:0]       widx_s;
   logic                 idx_valid_s;
   logic [EIW-1:0]       eff_s;

   // Config handshake decode: a word arriving after a complete load restarts at word 0.
   always_comb begin
      acc_s = cfg_valid & cfg_ready_r;
      if (cfg_done_r) begin
         widx_s = {WCW{1'b0}};
      end else begin
         widx_s = word_cnt_r;
      end
      last_s = (widx_s == WORD_LAST);
   end

   // Config storage: word counter, done flag and the sweep-start pattern.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_cnt_r <= {WCW{1'b0}};
         cfg_done_r <= 1'b0;
         ss_r       <= {SS_BITS{1'b0}};
      end else if (acc_s) begin
         for (int i = 0; i < SS_BITS; i++) begin
            if ((i / CFG_W) == int'(widx_s)) begin
               ss_r[i] <= cfg_data[i % CFG_W];
            end
         end
         word_cnt_r <= last_s ? {WCW{1'b0}} : (widx_s + {{(WCW-1){1'b0}}, 1'b1});
         cfg_done_r <= last_s;
      end
   end

   // Pass sequencer: state, cycle counter and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= UNCFG;
         cfg_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         jd_r        <= 1'b0;
         ci_r        <= {CIW{1'b0}};
      end else begin
         jd_r <= 1'b0;
         case (state_r)
            UNCFG: begin
               if (acc_s && last_s) begin
                  state_r <= IDLE;
               end
            end
            IDLE: begin
               // A config word in the same cycle takes precedence over start.
               if (start && cfg_done_r && !acc_s) begin
                  state_r     <= RUN;
                  busy_r      <= 1'b1;
                  cfg_ready_r <= 1'b0;
                  ci_r        <= {CIW{1'b0}};
               end
            end
            RUN: begin
               if (abort) begin
                  state_r     <= IDLE;
                  busy_r      <= 1'b0;
                  cfg_ready_r <= 1'b1;
                  ci_r        <= {CIW{1'b0}};
               end else if (!stall) begin
                  if (ci_r == CI_LAST) begin
                     jd_r <= 1'b1;
                     ci_r <= {CIW{1'b0}};
                     if (!continuous) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        cfg_ready_r <= 1'b1;
                     end
                  end else begin
                     ci_r <= ci_r + {{(CIW-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               state_r     <= UNCFG;
               busy_r      <= 1'b0;
               cfg_ready_r <= 1'b1;
               ci_r        <= {CIW{1'b0}};
            end
         endcase
      end
   end

   // Index decode for interleaver_set; a single working cycle always maps to index 0.
   always_comb begin
      idx_valid_s = busy_r & ~stall & ({1'b0, ci_r} < NW_X);
      if (NW == 1) begin
         eff_s = {EIW{1'b0}};
      end else begin
         eff_s = ci_r[EIW-1:0];
      end
   end

`ifdef INTLV_SWEEP_MON_EN
   localparam int SWL = $clog2(p / z);
   generate
      if (fo == 1) begin : g_one_sweep
         assign sweep_num   = {SNW{1'b0}};
         assign sweep_first = idx_valid_s & (eff_s == {EIW{1'b0}});
      end else if (SWL == 0) begin : g_one_cycle_sweep
         assign sweep_num   = eff_s;
         assign sweep_first = idx_valid_s;
      end else begin : g_multi_cycle_sweep
         assign sweep_num   = eff_s[EIW-1:SWL];
         assign sweep_first = idx_valid_s & (eff_s[SWL-1:0] == {SWL{1'b0}});
      end
   endgenerate
`else
   assign sweep_num   = {SNW{1'b0}};
   assign sweep_first = 1'b0;
`endif

   assign cfg_ready       = cfg_ready_r;
   assign cfg_done        = cfg_done_r;
   assign sweepstart      = ss_r;
   assign busy            = busy_r;
   assign cycle_index     = ci_r;
   assign eff_cycle_index = eff_s;
   assign idx_valid       = idx_valid_s;
   assign junction_done   = jd_r;

endmodule
